// File: rtl/video_timing_pkg.sv
// Shared definitions for the raster timing generator.
// Holds the default Pong raster constants so instantiations can use named
// values, and the helpers the axis counters use to decode windows and
// validate their timing parameters at elaboration.
package video_timing_pkg;

    // Default counter widths
    localparam int PONG_HW = 9;
    localparam int PONG_VW = 9;
    localparam int PONG_FW = 8;

    // Default horizontal timing (pixels)
    localparam int PONG_H_TOTAL      = 455;
    localparam int PONG_H_ACTIVE     = 375;
    localparam int PONG_H_SYNC_START = 407;
    localparam int PONG_H_SYNC_END   = 439;

    // Default vertical timing (lines)
    localparam int PONG_V_TOTAL      = 262;
    localparam int PONG_V_ACTIVE     = 240;
    localparam int PONG_V_SYNC_START = 248;
    localparam int PONG_V_SYNC_END   = 252;

    // Default sync polarity (0 = active-low)
    localparam bit PONG_H_POL = 1'b0;
    localparam bit PONG_V_POL = 1'b0;

    // True when lo <= v < hi.
    function automatic logic in_window(input int unsigned v,
                                       input int unsigned lo,
                                       input int unsigned hi);
        return (v >= lo) && (v < hi);
    endfunction

    // Legal axis timing: fits the counter and keeps
    // 0 < active < sync_start < sync_end <= total.
    function automatic logic axis_params_ok(input int total,
                                            input int active,
                                            input int sync_start,
                                            input int sync_end,
                                            input int w);
        return (w > 0) && (w < 31) && (total <= (1 << w)) &&
               (active > 0) && (active < sync_start) &&
               (sync_start < sync_end) && (sync_end <= total);
    endfunction

endpackage

// File: rtl/video_timing_if.sv
// Timing bundle between the raster generator and its consumers.
// Signals:
//   ce             pixel clock-enable (consumer side drives it)
//   hcount/vcount  pixel and line position
//   hblank/vblank  high outside the active region
//   hsync/vsync    sync at the configured polarity inside the sync window
//   hreset/vreset  one-clk strobes on last pixel of line / of frame
//   frame          completed-frame count
// Modports: master = the generator, slave = the consumer.
interface video_timing_if #(
    parameter int HW = 9,
    parameter int VW = 9,
    parameter int FW = 8
) ();
    logic          ce;
    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic          hblank;
    logic          vblank;
    logic          hsync;
    logic          vsync;
    logic          hreset;
    logic          vreset;
    logic [FW-1:0] frame;

    modport master (
        input  ce,
        output hcount, vcount, hblank, vblank, hsync, vsync,
               hreset, vreset, frame
    );

    modport slave (
        output ce,
        input  hcount, vcount, hblank, vblank, hsync, vsync,
               hreset, vreset, frame
    );
endinterface

// File: rtl/video_timing_axis.sv
// One raster axis: a wrapping position counter with registered blank and
// sync decode.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   ce_in  advance enable
//   count  current position (0..TOTAL-1)
//   blank  high for count >= ACTIVE
//   sync   POL inside [SYNC_START, SYNC_END), !POL elsewhere
//   wrap   combinational: ce_in high on the last position
module timing_axis
    import video_timing_pkg::*;
#(
    parameter int W          = 9,
    parameter int TOTAL      = 455,
    parameter int ACTIVE     = 375,
    parameter int SYNC_START = 407,
    parameter int SYNC_END   = 439,
    parameter bit POL        = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ce_in,
    output logic [W-1:0] count,
    output logic         blank,
    output logic         sync,
    output logic         wrap
);

    if (!axis_params_ok(TOTAL, ACTIVE, SYNC_START, SYNC_END, W)) begin : g_param_err
        $error("timing_axis: illegal timing parameters");
    end

    localparam logic [W-1:0] LAST = W'(TOTAL - 1);

    logic [W-1:0] count_q, count_d;
    logic         blank_q, blank_d;
    logic         sync_q, sync_d;

    // Decode the next count so the registered levels line up with the
    // count presented on the same cycle.
    always_comb begin
        wrap    = ce_in && (count_q == LAST);
        count_d = count_q;
        if (wrap) begin
            count_d = '0;
        end else if (ce_in) begin
            count_d = count_q + 1'b1;
        end
        blank_d = (32'(count_d) >= ACTIVE);
        sync_d  = in_window(32'(count_d), SYNC_START, SYNC_END) ? POL : !POL;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            blank_q <= 1'b0;
            sync_q  <= !POL;
        end else begin
            count_q <= count_d;
            blank_q <= blank_d;
            sync_q  <= sync_d;
        end
    end

    assign count = count_q;
    assign blank = blank_q;
    assign sync  = sync_q;

endmodule

// File: rtl/video_timing.sv
// Parametrised raster timing generator.
// Two timing_axis instances: horizontal advances on ce, vertical advances
// on the horizontal wrap (hreset), so vertical levels only move at line
// boundaries. A frame counter advances on the vertical wrap (vreset).
// Ports:
//   clk    system clock
//   reset  synchronous, active-high; wins over ce
//   vt     timing bundle (master side): ce in; counts, blank, sync,
//          strobes and frame count out
module video_timing
    import video_timing_pkg::*;
#(
    parameter int HW           = PONG_HW,
    parameter int VW           = PONG_VW,
    parameter int FW           = PONG_FW,
    parameter int H_TOTAL      = PONG_H_TOTAL,
    parameter int H_ACTIVE     = PONG_H_ACTIVE,
    parameter int H_SYNC_START = PONG_H_SYNC_START,
    parameter int H_SYNC_END   = PONG_H_SYNC_END,
    parameter int V_TOTAL      = PONG_V_TOTAL,
    parameter int V_ACTIVE     = PONG_V_ACTIVE,
    parameter int V_SYNC_START = PONG_V_SYNC_START,
    parameter int V_SYNC_END   = PONG_V_SYNC_END,
    parameter bit H_POL        = PONG_H_POL,
    parameter bit V_POL        = PONG_V_POL
) (
    input logic            clk,
    input logic            reset,
    video_timing_if.master vt
);

    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic          hblank, hsync, hreset;
    logic          vblank, vsync, vreset;
    logic [FW-1:0] frame_q, frame_d;

    timing_axis #(
        .W(HW), .TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE),
        .SYNC_START(H_SYNC_START), .SYNC_END(H_SYNC_END), .POL(H_POL)
    ) u_h (
        .clk   (clk),
        .reset (reset),
        .ce_in (vt.ce),
        .count (hcount),
        .blank (hblank),
        .sync  (hsync),
        .wrap  (hreset)
    );

    // hreset already carries ce, so vreset is hreset on the last line.
    timing_axis #(
        .W(VW), .TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE),
        .SYNC_START(V_SYNC_START), .SYNC_END(V_SYNC_END), .POL(V_POL)
    ) u_v (
        .clk   (clk),
        .reset (reset),
        .ce_in (hreset),
        .count (vcount),
        .blank (vblank),
        .sync  (vsync),
        .wrap  (vreset)
    );

    // Completed-frame count; wraps naturally at 2**FW.
    always_comb begin
        frame_d = frame_q;
        if (vreset) begin
            frame_d = frame_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_q <= '0;
        end else begin
            frame_q <= frame_d;
        end
    end

    assign vt.hcount = hcount;
    assign vt.vcount = vcount;
    assign vt.hblank = hblank;
    assign vt.vblank = vblank;
    assign vt.hsync  = hsync;
    assign vt.vsync  = vsync;
    assign vt.hreset = hreset;
    assign vt.vreset = vreset;
    assign vt.frame  = frame_q;

endmodule
